// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one registered comparator among NUM_REQ requesters.
// Each grant runs IDLE -> ISSUE -> CAPTURE, so a new grant can start every 3 cycles.
// Build option: define CMP_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, arbitration is fixed priority (lowest index wins) and no pointer register exists.
`timescale 1ns/1ps
module cmp_arbiter #(
  parameter int WIDTH_A       = 8,
  parameter int WIDTH_B       = 8,
  parameter int WIDTH_CMP_OUT = 16,
  parameter int NUM_REQ       = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  input  logic [NUM_REQ*WIDTH_A-1:0] REQ_A,
  input  logic [NUM_REQ*WIDTH_B-1:0] REQ_B,
  input  logic [NUM_REQ*2-1:0]       REQ_FUN,
  output logic [NUM_REQ-1:0]         REQ_READY,
  output logic [NUM_REQ-1:0]         RSP_VALID,
  output logic [WIDTH_CMP_OUT-1:0]   RSP_DATA,
  output logic [2:0]                 GRANT_ID,
  output logic                       BUSY,
  output logic [WIDTH_A-1:0]         CMP_A,
  output logic [WIDTH_B-1:0]         CMP_B,
  output logic [1:0]                 CMP_FUN,
  output logic                       CMP_Enable,
  input  logic [WIDTH_CMP_OUT-1:0]   CMP_OUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                   state_q;
  logic [NUM_REQ-1:0]       req_ready_q, rsp_valid_q;
  logic [WIDTH_CMP_OUT-1:0] rsp_data_q;
  logic [2:0]               grant_id_q;
  logic                     busy_q, cmp_en_q;
  logic [WIDTH_A-1:0]       cmp_a_q;
  logic [WIDTH_B-1:0]       cmp_b_q;
  logic [1:0]               cmp_fun_q;

  logic       any_req;
  logic [2:0] grant_d;

  assign any_req = |REQ_VALID;

`ifdef CMP_ARB_ROUND_ROBIN_EN
  // Index of the last granted requester; search begins one past it.
  logic [2:0] rr_q;

  // Round-robin winner: first valid requester starting at rr_q+1, wrapping.
  always_comb begin
    automatic logic found = 1'b0;
    automatic int   idx   = 0;
    grant_d = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && REQ_VALID[idx]) begin
        found   = 1'b1;
        grant_d = 3'(idx);
      end
    end
  end
`else
  // Fixed priority winner: lowest valid index wins (scan high to low, last write wins).
  always_comb begin
    grant_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (REQ_VALID[i]) grant_d = 3'(i);
  end
`endif

  // Control FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      cmp_en_q    <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_fun_q   <= '0;
`ifdef CMP_ARB_ROUND_ROBIN_EN
      rr_q        <= 3'(NUM_REQ - 1);
`endif
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      cmp_en_q    <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          state_q     <= ISSUE;
          busy_q      <= 1'b1;
          grant_id_q  <= grant_d;
          cmp_a_q     <= REQ_A[grant_d*WIDTH_A +: WIDTH_A];
          cmp_b_q     <= REQ_B[grant_d*WIDTH_B +: WIDTH_B];
          cmp_fun_q   <= REQ_FUN[grant_d*2 +: 2];
          req_ready_q <= NUM_REQ'(1) << grant_d;
          cmp_en_q    <= 1'b1;
`ifdef CMP_ARB_ROUND_ROBIN_EN
          rr_q        <= grant_d;
`endif
        end
        // Comparator registers its result at the end of this cycle.
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          rsp_data_q  <= CMP_OUT;
          rsp_valid_q <= NUM_REQ'(1) << grant_id_q;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_READY  = req_ready_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_DATA   = rsp_data_q;
  assign GRANT_ID   = grant_id_q;
  assign BUSY       = busy_q;
  assign CMP_A      = cmp_a_q;
  assign CMP_B      = cmp_b_q;
  assign CMP_FUN    = cmp_fun_q;
  assign CMP_Enable = cmp_en_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with a behavioural registered comparator
// and a response scoreboard (expected id/data pushed at grant, popped on RSP_VALID).
`timescale 1ns/1ps
module tb_cmp_arbiter;
  localparam int N = 4;

  logic          CLK = 0, RST = 0;
  logic [N-1:0]  REQ_VALID = '0;
  logic [N*8-1:0] REQ_A = '0, REQ_B = '0;
  logic [N*2-1:0] REQ_FUN = '0;
  logic [N-1:0]  REQ_READY, RSP_VALID;
  logic [15:0]   RSP_DATA, CMP_OUT;
  logic [2:0]    GRANT_ID;
  logic          BUSY, CMP_Enable;
  logic [7:0]    CMP_A, CMP_B;
  logic [1:0]    CMP_FUN;

  cmp_arbiter #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_CMP_OUT(16), .NUM_REQ(N)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_FUN(REQ_FUN), .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID),
    .RSP_DATA(RSP_DATA), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .CMP_A(CMP_A),
    .CMP_B(CMP_B), .CMP_FUN(CMP_FUN), .CMP_Enable(CMP_Enable), .CMP_OUT(CMP_OUT));

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;

  typedef struct { logic [2:0] id; logic [15:0] data; } exp_t;
  exp_t sb[$];

  // Comparator model: 00 -> 0, 01 -> eq in bit0, 10 -> gt in bit1, 11 -> lt in bit2.
  function automatic logic [15:0] cmpf(logic [7:0] a, logic [7:0] b, logic [1:0] f);
    case (f)
      2'b01:   return {15'd0, a == b};
      2'b10:   return {14'd0, a > b, 1'b0};
      2'b11:   return {13'd0, a < b, 2'b00};
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge CLK) if (CMP_Enable) CMP_OUT <= cmpf(CMP_A, CMP_B, CMP_FUN);
  initial CMP_OUT = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop and compare on every response pulse; also one-hot sanity.
  always @(negedge CLK) begin
    if (RST) begin
      if (!$onehot0(REQ_READY)) chk("ready_onehot", REQ_READY, 0);
      if (!$onehot0(RSP_VALID)) chk("rsp_onehot", RSP_VALID, 0);
    end
    if (RSP_VALID !== '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", RSP_VALID, 0);
      else begin
        automatic exp_t e = sb.pop_front();
        chk("sb_rsp_valid", RSP_VALID, 64'(4'b0001 << e.id));
        chk("sb_rsp_data", RSP_DATA, e.data);
      end
    end
  end

  task automatic tick(); @(posedge CLK); #1; endtask

  task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [1:0] f);
    REQ_A[i*8 +: 8] = a; REQ_B[i*8 +: 8] = b; REQ_FUN[i*2 +: 2] = f;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ready"}, REQ_READY, 0);
    chk({tag, "_rspv"}, RSP_VALID, 0);
    chk({tag, "_rspd"}, RSP_DATA, 0);
    chk({tag, "_gid"}, GRANT_ID, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_cmp"}, {CMP_A, CMP_B, CMP_FUN, CMP_Enable}, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    RST = 1; tick();

    // Single request on requester 0, A==B, FUN=eq -> data 1
    set_req(0, 8'h05, 8'h05, 2'b01);
    REQ_VALID = 4'b0001;
    sb.push_back('{3'd0, 16'h0001});
    tick();                                   // cycle 1
    REQ_VALID = '0;
    chk("s_ready", REQ_READY, 4'b0001);
    chk("s_en_c1", CMP_Enable, 1);
    chk("s_busy_c1", BUSY, 1);
    chk("s_gid", GRANT_ID, 0);
    tick();                                   // cycle 2
    chk("s_en_c2", CMP_Enable, 0);
    chk("s_ready_c2", REQ_READY, 0);
    chk("s_busy_c2", BUSY, 1);
    tick();                                   // cycle 3
    chk("s_rspv_c3", RSP_VALID, 4'b0001);
    chk("s_rspd_c3", RSP_DATA, 16'h0001);
    chk("s_busy_c3", BUSY, 0);
    tick();
    chk("s_rspv_c4", RSP_VALID, 0);
    chk("s_hold_data", RSP_DATA, 16'h0001);
    chk("s_hold_a", CMP_A, 8'h05);

    // Requester 2, A=9 B=3 FUN=gt -> data 2; late request on 3 raised and withdrawn
    set_req(2, 8'h09, 8'h03, 2'b10);
    REQ_VALID = 4'b0100;
    sb.push_back('{3'd2, 16'h0002});
    tick();                                   // cycle 1: ISSUE
    REQ_VALID = 4'b1000;                      // late request during ISSUE
    chk("f_ready", REQ_READY, 4'b0100);
    chk("f_cmp", {CMP_A, CMP_B, CMP_FUN}, {8'h09, 8'h03, 2'b10});
    chk("f_gid", GRANT_ID, 2);
    tick();                                   // cycle 2: CAPTURE
    REQ_VALID = '0;                           // withdrawn before IDLE
    tick();                                   // cycle 3
    chk("f_rspd", RSP_DATA, 16'h0002);
    tick();
    chk("late_busy", BUSY, 0);
    chk("late_ready", REQ_READY, 0);

    // FUN=00 passes through, result 0
    set_req(2, 8'h09, 8'h03, 2'b00);
    REQ_VALID = 4'b0100;
    sb.push_back('{3'd2, 16'h0000});
    tick(); REQ_VALID = '0;
    chk("z_fun", CMP_FUN, 2'b00);
    tick(); tick();
    chk("z_rspd", RSP_DATA, 0);
    tick();

    // Reset during CAPTURE: no response, outputs cleared
    set_req(1, 8'h02, 8'h07, 2'b11);
    REQ_VALID = 4'b0010;
    tick(); REQ_VALID = '0;                   // ISSUE
    tick();                                   // CAPTURE
    RST = 0; #1;
    chk_all_zero("rst_mid");
    tick();
    RST = 1;
    tick(); tick();
    chk("rst_no_rsp", RSP_VALID, 0);
    // Request after release completes normally: 2<7 -> lt -> 4
    REQ_VALID = 4'b0010;
    sb.push_back('{3'd1, 16'h0004});
    tick(); REQ_VALID = '0;
    chk("post_rst_ready", REQ_READY, 4'b0010);
    tick(); tick();
    chk("post_rst_rspd", RSP_DATA, 16'h0004);
    tick();

    // Reset so the round-robin pointer starts at NUM_REQ-1
    RST = 0; tick(); RST = 1; tick();

`ifdef CMP_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < N; i++) set_req(i, 8'(i), 8'(i), 2'b01);
    REQ_VALID = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      sb.push_back('{3'(g % N), 16'h0001});
      tick();
      chk($sformatf("rr_ready%0d", g), REQ_READY, 64'(4'b0001 << (g % N)));
      chk($sformatf("rr_gid%0d", g), GRANT_ID, g % N);
      tick(); tick();
    end
    REQ_VALID = '0;
`else
    set_req(1, 8'h11, 8'h11, 2'b01);
    set_req(2, 8'h22, 8'h22, 2'b01);
    REQ_VALID = 4'b0110;
    for (int g = 0; g < 4; g++) begin
      sb.push_back('{3'd1, 16'h0001});
      tick();
      chk($sformatf("fp_ready%0d", g), REQ_READY, 4'b0010);
      chk($sformatf("fp_a%0d", g), CMP_A, 8'h11);
      tick(); tick();
    end
    REQ_VALID = '0;
`endif
    tick(); tick();
    chk("sb_drained", sb.size(), 0);
    chk("end_busy", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_A, default 8, operand A width.
REQ-002 SHALL have parameter WIDTH_B, default 8, operand B width.
REQ-003 SHALL have parameter WIDTH_CMP_OUT, default 16, comparator result width.
REQ-004 SHALL have parameter NUM_REQ, default 4, number of requesters, range 2..8.
REQ-005 SHALL have ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- REQ_VALID  input  NUM_REQ  per-requester request; bit i = requester i.
- REQ_A  input  NUM_REQ*WIDTH_A  packed operand A; slice i = requester i.
- REQ_B  input  NUM_REQ*WIDTH_B  packed operand B; slice i = requester i.
- REQ_FUN  input  NUM_REQ*2  packed 2-bit compare function per requester.
- REQ_READY  output  NUM_REQ  one-hot, one-cycle accept pulse.
- RSP_VALID  output  NUM_REQ  one-hot, one-cycle result-valid pulse.
- RSP_DATA  output  WIDTH_CMP_OUT  captured comparator result.
- GRANT_ID  output  3  index of the current or last granted requester.
- BUSY  output  1  high whenever the FSM is not IDLE.
- CMP_A  output  WIDTH_A  operand A to comparator.
- CMP_B  output  WIDTH_B  operand B to comparator.
- CMP_FUN  output  2  function code to comparator.
- CMP_Enable  output  1  comparator enable.
- CMP_OUT  input  WIDTH_CMP_OUT  comparator registered result.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, CAPTURE; all outputs registered.
REQ-007 IDLE: if any REQ_VALID bit is set, SHALL select winner W, latch REQ_A/REQ_B/REQ_FUN slice W into CMP_A/CMP_B/CMP_FUN, load GRANT_ID=W, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-008 In the first ISSUE cycle, SHALL assert REQ_READY[W] and CMP_Enable for exactly one cycle, then go to CAPTURE.
REQ-009 CAPTURE: SHALL load RSP_DATA from CMP_OUT, assert RSP_VALID[W] in the following cycle for exactly one cycle, and return to IDLE.
REQ-010 Timing: valid seen in cycle 0 -> REQ_READY and CMP_Enable in cycle 1 -> RSP_VALID in cycle 3; the next grant is possible in cycle 3, giving a 3-cycle issue interval.
REQ-011 CMP_Enable SHALL be 0 in IDLE and CAPTURE.
REQ-012 CMP_A/CMP_B/CMP_FUN SHALL hold their latched values until the next grant.
REQ-013 RSP_DATA SHALL hold its value until the next CAPTURE.
REQ-014 REQ_VALID is sampled only in IDLE; a requester dropping valid before grant SHALL be skipped with no side effect.
REQ-015 Requests asserted in ISSUE or CAPTURE SHALL be ignored until IDLE.
REQ-016 A requester holding REQ_VALID after its REQ_READY pulse SHALL be treated as a new request.
REQ-017 REQ_FUN SHALL pass through unmodified, including 2'b00 (result 0).
REQ-018 At most one REQ_READY bit and at most one RSP_VALID bit SHALL be high in any cycle.
REQ-019 BUSY SHALL equal (state != IDLE).

Reset
REQ-020 RST low SHALL asynchronously force:
- state IDLE;
- REQ_READY, RSP_VALID, RSP_DATA, GRANT_ID, CMP_A, CMP_B, CMP_FUN, CMP_Enable, BUSY to 0;
- round-robin pointer to NUM_REQ-1.
REQ-021 Reset mid-operation SHALL abandon the in-flight request with no RSP_VALID; the first grant after release follows REQ-007.

Configuration
REQ-022 Macro CMP_ARB_ROUND_ROBIN_EN: when defined, arbitration SHALL be round-robin.
- Search starts at (last granted + 1) mod NUM_REQ.
- The pointer updates on each grant.
REQ-023 Without CMP_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest index wins, and SHALL contain no pointer register.

Verification
REQ-024 Single request: REQ_VALID=0001, A=8'h05, B=8'h05, FUN=01, comparator CMP_OUT=1 -> REQ_READY=0001 in cycle 1, CMP_Enable high in cycle 1 only, RSP_VALID=0001 and RSP_DATA=16'h0001 in cycle 3.
REQ-025 Contention with macro defined: REQ_VALID=1111 held -> grant order 0,1,2,3,0 with REQ_READY pulses 3 cycles apart.
REQ-026 Contention without macro: REQ_VALID=0110 held -> requester 1 granted every time; requester 2 never granted.
REQ-027 Compare functions: requester 2, A=8'h09, B=8'h03, FUN=10 -> CMP_A=9, CMP_B=3, CMP_FUN=10 during ISSUE, RSP_VALID=0100 with RSP_DATA=2; FUN=00 -> RSP_DATA=0.
REQ-028 Reset in CAPTURE: RST low for 1 cycle -> all outputs 0, no RSP_VALID; a new request after release completes normally.
REQ-029 Late/withdrawn requests: REQ_VALID[3] raised during ISSUE and dropped before IDLE -> no REQ_READY[3], BUSY low after completion.
